// File: rtl/e203_lsu_biu_osd_buf_pkg.sv
// Shared constants and types for the LSU-to-BIU outstanding buffer.
// The optional error-address capture is enabled by E203_LSU_OSD_ERR_CAPTURE_EN.
package e203_lsu_biu_osd_buf_pkg;

    localparam int E203_ADDR_SIZE   = 32;
    localparam int E203_XLEN        = 32;
    localparam int E203_LSU_OSD_MAX = 2;

    typedef struct packed {
        logic       read;
        logic       lock;
        logic       excl;
        logic [1:0] size;
    } icb_cmd_ctrl_t;

    localparam icb_cmd_ctrl_t CMD_CTRL_RST = '{read: 1'b0, lock: 1'b0, excl: 1'b0, size: 2'b00};

    // A depth-1 FIFO still needs a 1-bit pointer to keep the vectors legal.
    function automatic int osd_ptr_w(input int dp);
        return (dp > 1) ? $clog2(dp) : 1;
    endfunction

endpackage

// File: rtl/e203_lsu_biu_osd_buf_chk.sv
// Simulation-only invariants of the outstanding buffer.
module e203_lsu_biu_osd_buf_chk #(
    parameter int OSD_MAX = 2,
    parameter int CW      = 2
) (
    input logic          clk,
    input logic          rst,
    input logic          o_rsp_valid,
    input logic          rsp_full,
    input logic          rsp_empty,
    input logic          addr_empty,
    input logic [CW-1:0] osd_cnt
);

    // The outstanding cap guarantees the BIU never offers a response into a full buffer.
    a_no_rsp_overflow: assert property (@(posedge clk) disable iff (rst) !(o_rsp_valid && rsp_full));

    a_cnt_cap: assert property (@(posedge clk) disable iff (rst) osd_cnt <= CW'(OSD_MAX));

    a_addr_tracks_rsp: assert property (@(posedge clk) disable iff (rst) !(!rsp_empty && addr_empty));

endmodule

// File: rtl/e203_lsu_osd_fifo.sv
// Register-based synchronous FIFO (DP entries x DW bits); the head is read
// straight from storage, so a pushed entry is visible on the next cycle.
module e203_lsu_osd_fifo
    import e203_lsu_biu_osd_buf_pkg::*;
#(
    parameter int DP = 2,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int PW = osd_ptr_w(DP);
    localparam int CW = $clog2(DP) + 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DP - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DP);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [DW-1:0] mem_r [DP];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] cnt_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Pop on empty is ignored; push on full cannot happen but is guarded anyway.
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            for (int i = 0; i < DP; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= (wr_ptr_r == LAST_PTR) ? {PW{1'b0}} : wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= (rd_ptr_r == LAST_PTR) ? {PW{1'b0}} : rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_ONE;
                2'b01:   cnt_r <= cnt_r - CNT_ONE;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = (cnt_r == DEPTH_C);
    assign empty = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/e203_lsu_biu_osd_buf.sv
// Registered cmd slice, outstanding cap and response buffer between the LSU and the BIU.
// Optional error-address capture: define E203_LSU_OSD_ERR_CAPTURE_EN.
module e203_lsu_biu_osd_buf
    import e203_lsu_biu_osd_buf_pkg::*;
#(
    parameter int OSD_MAX = E203_LSU_OSD_MAX,
    parameter int AW      = E203_ADDR_SIZE,
    parameter int DW      = E203_XLEN
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     i_icb_cmd_valid,
    output logic                     i_icb_cmd_ready,
    input  logic [AW-1:0]            i_icb_cmd_addr,
    input  logic                     i_icb_cmd_read,
    input  logic [DW-1:0]            i_icb_cmd_wdata,
    input  logic [DW/8-1:0]          i_icb_cmd_wmask,
    input  logic                     i_icb_cmd_lock,
    input  logic                     i_icb_cmd_excl,
    input  logic [1:0]               i_icb_cmd_size,

    output logic                     i_icb_rsp_valid,
    input  logic                     i_icb_rsp_ready,
    output logic                     i_icb_rsp_err,
    output logic                     i_icb_rsp_excl_ok,
    output logic [DW-1:0]            i_icb_rsp_rdata,
    output logic [AW-1:0]            i_icb_rsp_addr,

    output logic                     o_icb_cmd_valid,
    input  logic                     o_icb_cmd_ready,
    output logic [AW-1:0]            o_icb_cmd_addr,
    output logic                     o_icb_cmd_read,
    output logic [DW-1:0]            o_icb_cmd_wdata,
    output logic [DW/8-1:0]          o_icb_cmd_wmask,
    output logic                     o_icb_cmd_lock,
    output logic                     o_icb_cmd_excl,
    output logic [1:0]               o_icb_cmd_size,

    input  logic                     o_icb_rsp_valid,
    output logic                     o_icb_rsp_ready,
    input  logic                     o_icb_rsp_err,
    input  logic                     o_icb_rsp_excl_ok,
    input  logic [DW-1:0]            o_icb_rsp_rdata,

`ifdef E203_LSU_OSD_ERR_CAPTURE_EN
    input  logic                     err_clr,
    output logic                     err_vld,
    output logic [AW-1:0]            err_addr,
`endif
    output logic [$clog2(OSD_MAX):0] osd_cnt,
    output logic                     osd_idle
);

    localparam int CW = $clog2(OSD_MAX) + 1;
    localparam int RW = DW + 2;
    localparam logic [CW-1:0] OSD_MAX_C = CW'(OSD_MAX);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic            slice_vld_r;
    logic [AW-1:0]   slice_addr_r;
    logic [DW-1:0]   slice_wdata_r;
    logic [DW/8-1:0] slice_wmask_r;
    icb_cmd_ctrl_t   slice_ctrl_r;
    logic [CW-1:0]   osd_cnt_r;

    logic            cmd_ready_s;
    logic            cmd_hsk_s;
    logic            rsp_hsk_s;
    logic            o_rsp_hsk_s;
    logic            addr_full_s;
    logic            addr_empty_s;
    logic            rsp_full_s;
    logic            rsp_empty_s;
    logic [RW-1:0]   rsp_din_s;
    logic [RW-1:0]   rsp_dout_s;

    // Ready depends only on registered state and the BIU ready, never on cmd valid.
    assign cmd_ready_s = (osd_cnt_r < OSD_MAX_C) & (~slice_vld_r | o_icb_cmd_ready) & ~addr_full_s;
    assign cmd_hsk_s   = i_icb_cmd_valid & cmd_ready_s;
    assign rsp_hsk_s   = ~rsp_empty_s & i_icb_rsp_ready;
    assign o_rsp_hsk_s = o_icb_rsp_valid & ~rsp_full_s;

    // One-entry cmd slice: reloads on accept, empties on drain, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            slice_vld_r   <= 1'b0;
            slice_addr_r  <= {AW{1'b0}};
            slice_wdata_r <= {DW{1'b0}};
            slice_wmask_r <= {(DW/8){1'b0}};
            slice_ctrl_r  <= CMD_CTRL_RST;
        end else if (cmd_hsk_s) begin
            slice_vld_r   <= 1'b1;
            slice_addr_r  <= i_icb_cmd_addr;
            slice_wdata_r <= i_icb_cmd_wdata;
            slice_wmask_r <= i_icb_cmd_wmask;
            slice_ctrl_r  <= '{read: i_icb_cmd_read, lock: i_icb_cmd_lock,
                               excl: i_icb_cmd_excl, size: i_icb_cmd_size};
        end else if (o_icb_cmd_ready) begin
            slice_vld_r   <= 1'b0;
        end
    end

    // Outstanding count: accepted commands minus responses delivered to the LSU.
    always_ff @(posedge clk) begin
        if (rst) begin
            osd_cnt_r <= {CW{1'b0}};
        end else begin
            case ({cmd_hsk_s, rsp_hsk_s})
                2'b10:   osd_cnt_r <= osd_cnt_r + CNT_ONE;
                2'b01:   osd_cnt_r <= osd_cnt_r - CNT_ONE;
                default: osd_cnt_r <= osd_cnt_r;
            endcase
        end
    end

    e203_lsu_osd_fifo #(.DP(OSD_MAX), .DW(AW)) u_addr_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_hsk_s),
        .pop   (rsp_hsk_s),
        .din   (i_icb_cmd_addr),
        .dout  (i_icb_rsp_addr),
        .full  (addr_full_s),
        .empty (addr_empty_s)
    );

    assign rsp_din_s = {o_icb_rsp_err, o_icb_rsp_excl_ok, o_icb_rsp_rdata};

    e203_lsu_osd_fifo #(.DP(OSD_MAX), .DW(RW)) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (o_rsp_hsk_s),
        .pop   (rsp_hsk_s),
        .din   (rsp_din_s),
        .dout  (rsp_dout_s),
        .full  (rsp_full_s),
        .empty (rsp_empty_s)
    );

`ifdef E203_LSU_OSD_ERR_CAPTURE_EN
    logic          err_vld_r;
    logic [AW-1:0] err_addr_r;

    // Sticky first-error address; a clear wins over a same-cycle capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_vld_r  <= 1'b0;
            err_addr_r <= {AW{1'b0}};
        end else if (err_clr) begin
            err_vld_r  <= 1'b0;
            err_addr_r <= {AW{1'b0}};
        end else if (rsp_hsk_s & rsp_dout_s[RW-1] & ~err_vld_r) begin
            err_vld_r  <= 1'b1;
            err_addr_r <= i_icb_rsp_addr;
        end
    end

    assign err_vld  = err_vld_r;
    assign err_addr = err_addr_r;
`endif

    assign i_icb_cmd_ready   = cmd_ready_s;
    assign i_icb_rsp_valid   = ~rsp_empty_s;
    assign i_icb_rsp_err     = rsp_dout_s[RW-1];
    assign i_icb_rsp_excl_ok = rsp_dout_s[RW-2];
    assign i_icb_rsp_rdata   = rsp_dout_s[DW-1:0];
    assign o_icb_rsp_ready   = ~rsp_full_s;

    assign o_icb_cmd_valid   = slice_vld_r;
    assign o_icb_cmd_addr    = slice_addr_r;
    assign o_icb_cmd_read    = slice_ctrl_r.read;
    assign o_icb_cmd_wdata   = slice_wdata_r;
    assign o_icb_cmd_wmask   = slice_wmask_r;
    assign o_icb_cmd_lock    = slice_ctrl_r.lock;
    assign o_icb_cmd_excl    = slice_ctrl_r.excl;
    assign o_icb_cmd_size    = slice_ctrl_r.size;

    assign osd_cnt  = osd_cnt_r;
    assign osd_idle = (osd_cnt_r == {CW{1'b0}}) & ~slice_vld_r;

    e203_lsu_biu_osd_buf_chk #(.OSD_MAX(OSD_MAX), .CW(CW)) u_chk (
        .clk         (clk),
        .rst         (rst),
        .o_rsp_valid (o_icb_rsp_valid),
        .rsp_full    (rsp_full_s),
        .rsp_empty   (rsp_empty_s),
        .addr_empty  (addr_empty_s),
        .osd_cnt     (osd_cnt_r)
    );

endmodule

// File: tb/tb_e203_lsu_biu_osd_buf.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_e203_lsu_biu_osd_buf;

    localparam int OSD_MAX = 2;

    typedef struct {
        logic [31:0] addr;
        logic        read;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        lock;
        logic        excl;
        logic [1:0]  size;
    } cmd_t;

    typedef struct {
        logic        err;
        logic        excl_ok;
        logic [31:0] rdata;
    } rsp_t;

    logic        clk, rst;
    logic        i_icb_cmd_valid, i_icb_cmd_ready, i_icb_cmd_read, i_icb_cmd_lock, i_icb_cmd_excl;
    logic [31:0] i_icb_cmd_addr, i_icb_cmd_wdata;
    logic [3:0]  i_icb_cmd_wmask;
    logic [1:0]  i_icb_cmd_size;
    logic        i_icb_rsp_valid, i_icb_rsp_ready, i_icb_rsp_err, i_icb_rsp_excl_ok;
    logic [31:0] i_icb_rsp_rdata, i_icb_rsp_addr;
    logic        o_icb_cmd_valid, o_icb_cmd_ready, o_icb_cmd_read, o_icb_cmd_lock, o_icb_cmd_excl;
    logic [31:0] o_icb_cmd_addr, o_icb_cmd_wdata;
    logic [3:0]  o_icb_cmd_wmask;
    logic [1:0]  o_icb_cmd_size;
    logic        o_icb_rsp_valid, o_icb_rsp_ready, o_icb_rsp_err, o_icb_rsp_excl_ok;
    logic [31:0] o_icb_rsp_rdata;
    logic [1:0]  osd_cnt;
    logic        osd_idle;
`ifdef E203_LSU_OSD_ERR_CAPTURE_EN
    logic        err_clr, err_vld;
    logic [31:0] err_addr;
`endif

    // Reference model: commands in the slice, commands at the BIU, addresses
    // awaiting an LSU response, and responses buffered for the LSU.
    cmd_t        m_slice[$];
    logic [31:0] m_biu[$];
    logic [31:0] m_addr[$];
    rsp_t        m_rsp[$];
    int          m_osd;
    logic        m_err_vld;
    logic [31:0] m_err_addr;

    int n_checks = 0;
    int n_errors = 0;

    e203_lsu_biu_osd_buf #(.OSD_MAX(OSD_MAX), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .i_icb_cmd_valid(i_icb_cmd_valid), .i_icb_cmd_ready(i_icb_cmd_ready),
        .i_icb_cmd_addr(i_icb_cmd_addr), .i_icb_cmd_read(i_icb_cmd_read),
        .i_icb_cmd_wdata(i_icb_cmd_wdata), .i_icb_cmd_wmask(i_icb_cmd_wmask),
        .i_icb_cmd_lock(i_icb_cmd_lock), .i_icb_cmd_excl(i_icb_cmd_excl),
        .i_icb_cmd_size(i_icb_cmd_size),
        .i_icb_rsp_valid(i_icb_rsp_valid), .i_icb_rsp_ready(i_icb_rsp_ready),
        .i_icb_rsp_err(i_icb_rsp_err), .i_icb_rsp_excl_ok(i_icb_rsp_excl_ok),
        .i_icb_rsp_rdata(i_icb_rsp_rdata), .i_icb_rsp_addr(i_icb_rsp_addr),
        .o_icb_cmd_valid(o_icb_cmd_valid), .o_icb_cmd_ready(o_icb_cmd_ready),
        .o_icb_cmd_addr(o_icb_cmd_addr), .o_icb_cmd_read(o_icb_cmd_read),
        .o_icb_cmd_wdata(o_icb_cmd_wdata), .o_icb_cmd_wmask(o_icb_cmd_wmask),
        .o_icb_cmd_lock(o_icb_cmd_lock), .o_icb_cmd_excl(o_icb_cmd_excl),
        .o_icb_cmd_size(o_icb_cmd_size),
        .o_icb_rsp_valid(o_icb_rsp_valid), .o_icb_rsp_ready(o_icb_rsp_ready),
        .o_icb_rsp_err(o_icb_rsp_err), .o_icb_rsp_excl_ok(o_icb_rsp_excl_ok),
        .o_icb_rsp_rdata(o_icb_rsp_rdata),
`ifdef E203_LSU_OSD_ERR_CAPTURE_EN
        .err_clr(err_clr), .err_vld(err_vld), .err_addr(err_addr),
`endif
        .osd_cnt(osd_cnt), .osd_idle(osd_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.addr  = $urandom() & 32'hFFFF_FFFC;
        c.read  = 1'($urandom_range(0, 1));
        c.wdata = $urandom();
        c.wmask = 4'($urandom_range(0, 15));
        c.lock  = 1'($urandom_range(0, 1));
        c.excl  = 1'($urandom_range(0, 1));
        c.size  = 2'($urandom_range(0, 3));
        return c;
    endfunction

    task automatic drive_cmd(input cmd_t c);
        i_icb_cmd_valid = 1'b1;
        i_icb_cmd_addr  = c.addr;
        i_icb_cmd_read  = c.read;
        i_icb_cmd_wdata = c.wdata;
        i_icb_cmd_wmask = c.wmask;
        i_icb_cmd_lock  = c.lock;
        i_icb_cmd_excl  = c.excl;
        i_icb_cmd_size  = c.size;
    endtask

    task automatic cmd_at(input logic [31:0] a);
        cmd_t c;
        c = rand_cmd();
        c.addr = a;
        c.read = 1'b1;
        drive_cmd(c);
    endtask

    task automatic biu_rsp(input logic [31:0] rd, input logic er);
        o_icb_rsp_valid   = 1'b1;
        o_icb_rsp_rdata   = rd;
        o_icb_rsp_err     = er;
        o_icb_rsp_excl_ok = rd[0];
    endtask

    // Advance one clock and apply the handshake rules to the model; ends 1 time unit after the edge.
    task automatic tick();
        bit   cmd_hs, drain, orsp_hs, irsp_hs, clr, cap;
        cmd_t c;
        rsp_t r;
        cmd_hs  = i_icb_cmd_valid && (m_osd < OSD_MAX) && (m_slice.size() == 0 || o_icb_cmd_ready);
        drain   = (m_slice.size() != 0) && o_icb_cmd_ready;
        orsp_hs = o_icb_rsp_valid && (m_rsp.size() < OSD_MAX);
        irsp_hs = (m_rsp.size() != 0) && i_icb_rsp_ready;
        cap     = irsp_hs && m_rsp[0].err && !m_err_vld;
        clr     = 1'b0;
`ifdef E203_LSU_OSD_ERR_CAPTURE_EN
        clr     = err_clr;
`endif
        c = '{i_icb_cmd_addr, i_icb_cmd_read, i_icb_cmd_wdata, i_icb_cmd_wmask,
              i_icb_cmd_lock, i_icb_cmd_excl, i_icb_cmd_size};
        r = '{o_icb_rsp_err, o_icb_rsp_excl_ok, o_icb_rsp_rdata};
        @(posedge clk);
        if (rst) begin
            m_slice.delete(); m_biu.delete(); m_addr.delete(); m_rsp.delete();
            m_osd = 0; m_err_vld = 1'b0; m_err_addr = 32'h0;
        end else begin
            if (clr) begin
                m_err_vld = 1'b0; m_err_addr = 32'h0;
            end else if (cap) begin
                m_err_vld = 1'b1; m_err_addr = m_addr[0];
            end
            if (irsp_hs) begin
                void'(m_rsp.pop_front()); void'(m_addr.pop_front()); m_osd--;
            end
            if (orsp_hs) begin
                void'(m_biu.pop_front()); m_rsp.push_back(r);
            end
            if (drain) m_biu.push_back(m_slice.pop_front().addr);
            if (cmd_hs) begin
                m_slice.push_back(c); m_addr.push_back(c.addr); m_osd++;
            end
        end
        #1;
    endtask

    // Return everything outstanding to the LSU with the BIU always responding.
    task automatic flush();
        i_icb_cmd_valid = 1'b0;
        o_icb_cmd_ready = 1'b1;
        i_icb_rsp_ready = 1'b1;
        for (int i = 0; i < 40 && (m_osd != 0 || m_rsp.size() != 0); i++) begin
            if (m_biu.size() != 0) biu_rsp($urandom(), 1'b0);
            else o_icb_rsp_valid = 1'b0;
            tick();
        end
        o_icb_rsp_valid = 1'b0;
        i_icb_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        o_icb_cmd_ready = 1'b1;
        #1;
        n_checks++; if (o_icb_cmd_valid !== 1'b0) begin n_errors++; $display("FAIL rst_ocmd_valid: got %b exp 0", o_icb_cmd_valid); end
        n_checks++; if (i_icb_rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rst_irsp_valid: got %b exp 0", i_icb_rsp_valid); end
        n_checks++; if (osd_idle !== 1'b1 || osd_cnt !== 2'd0) begin n_errors++; $display("FAIL rst_idle: got idle=%b cnt=%0d exp 1/0", osd_idle, osd_cnt); end
        n_checks++; if (i_icb_cmd_ready !== 1'b1 || o_icb_rsp_ready !== 1'b1) begin n_errors++; $display("FAIL rst_ready: got %b/%b exp 1/1", i_icb_cmd_ready, o_icb_rsp_ready); end
        n_checks++; if ((^{i_icb_rsp_rdata, i_icb_rsp_addr, o_icb_cmd_addr, o_icb_cmd_wdata, i_icb_rsp_err}) === 1'bx) begin n_errors++; $display("FAIL rst_xfree: data outputs contain X, exp none"); end
    endtask

    task automatic test_single_read();
        o_icb_cmd_ready = 1'b1; i_icb_rsp_ready = 1'b0;
        cmd_at(32'h8000_0010);
        #1;
        n_checks++; if (i_icb_cmd_ready !== 1'b1 || o_icb_cmd_valid !== 1'b0) begin n_errors++; $display("FAIL rd_accept: got rdy=%b ovld=%b exp 1/0", i_icb_cmd_ready, o_icb_cmd_valid); end
        tick();
        i_icb_cmd_valid = 1'b0;
        #1;
        n_checks++; if (o_icb_cmd_valid !== 1'b1 || o_icb_cmd_addr !== 32'h8000_0010 || o_icb_cmd_read !== 1'b1) begin n_errors++; $display("FAIL rd_ocmd: got v=%b a=%h r=%b exp 1/80000010/1", o_icb_cmd_valid, o_icb_cmd_addr, o_icb_cmd_read); end
        n_checks++; if (osd_cnt !== 2'd1) begin n_errors++; $display("FAIL rd_cnt1: got %0d exp 1", osd_cnt); end
        tick();
        biu_rsp(32'hDEAD_BEEF, 1'b0);
        #1;
        n_checks++; if (o_icb_rsp_ready !== 1'b1 || i_icb_rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rd_orsp: got ordy=%b ivld=%b exp 1/0", o_icb_rsp_ready, i_icb_rsp_valid); end
        tick();
        o_icb_rsp_valid = 1'b0; i_icb_rsp_ready = 1'b1;
        #1;
        n_checks++; if (i_icb_rsp_valid !== 1'b1 || i_icb_rsp_rdata !== 32'hDEAD_BEEF || i_icb_rsp_addr !== 32'h8000_0010) begin n_errors++; $display("FAIL rd_irsp: got v=%b d=%h a=%h exp 1/deadbeef/80000010", i_icb_rsp_valid, i_icb_rsp_rdata, i_icb_rsp_addr); end
        tick();
        i_icb_rsp_ready = 1'b0;
        #1;
        n_checks++; if (osd_cnt !== 2'd0 || osd_idle !== 1'b1 || i_icb_rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rd_done: got cnt=%0d idle=%b v=%b exp 0/1/0", osd_cnt, osd_idle, i_icb_rsp_valid); end
    endtask

    task automatic test_back_to_back();
        o_icb_cmd_ready = 1'b1; i_icb_rsp_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cmd_at(32'h300 + 32'(4 * k));
            #1;
            n_checks++; if (i_icb_cmd_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_accept%0d: got %b exp 1", k, i_icb_cmd_ready); end
            tick();
        end
        cmd_at(32'h308);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (i_icb_cmd_ready !== 1'b0 || osd_cnt !== 2'd2) begin n_errors++; $display("FAIL b2b_stall%0d: got rdy=%b cnt=%0d exp 0/2", k, i_icb_cmd_ready, osd_cnt); end
            tick();
        end
        biu_rsp(32'h1234_5678, 1'b0);
        tick();
        o_icb_rsp_valid = 1'b0; i_icb_rsp_ready = 1'b1;
        #1;
        n_checks++; if (i_icb_rsp_addr !== 32'h300 || i_icb_cmd_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_first_rsp: got a=%h rdy=%b exp 300/0", i_icb_rsp_addr, i_icb_cmd_ready); end
        tick();
        i_icb_rsp_ready = 1'b0;
        #1;
        n_checks++; if (i_icb_cmd_ready !== 1'b1 || osd_cnt !== 2'd1) begin n_errors++; $display("FAIL b2b_resume: got rdy=%b cnt=%0d exp 1/1", i_icb_cmd_ready, osd_cnt); end
        tick();
        i_icb_cmd_valid = 1'b0;
        #1;
        n_checks++; if (osd_cnt !== 2'd2 || o_icb_cmd_addr !== 32'h308) begin n_errors++; $display("FAIL b2b_third: got cnt=%0d a=%h exp 2/308", osd_cnt, o_icb_cmd_addr); end
        flush();
    endtask

    task automatic test_biu_stall();
        cmd_t c, d;
        o_icb_cmd_ready = 1'b0; i_icb_rsp_ready = 1'b0;
        c = rand_cmd();
        d = rand_cmd();
        d.addr = c.addr ^ 32'h10;
        drive_cmd(c);
        tick();
        drive_cmd(d);
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++; if ({o_icb_cmd_valid, o_icb_cmd_addr, o_icb_cmd_read, o_icb_cmd_wdata, o_icb_cmd_wmask, o_icb_cmd_lock, o_icb_cmd_excl, o_icb_cmd_size}
                            !== {1'b1, c.addr, c.read, c.wdata, c.wmask, c.lock, c.excl, c.size}) begin
                n_errors++; $display("FAIL stall_hold%0d: got a=%h d=%h exp a=%h d=%h", k, o_icb_cmd_addr, o_icb_cmd_wdata, c.addr, c.wdata);
            end
            n_checks++; if (i_icb_cmd_ready !== 1'b0) begin n_errors++; $display("FAIL stall_rdy%0d: got %b exp 0", k, i_icb_cmd_ready); end
            tick();
        end
        o_icb_cmd_ready = 1'b1;
        #1;
        n_checks++; if (i_icb_cmd_ready !== 1'b1) begin n_errors++; $display("FAIL stall_release: got %b exp 1", i_icb_cmd_ready); end
        tick();
        i_icb_cmd_valid = 1'b0;
        #1;
        n_checks++; if (o_icb_cmd_valid !== 1'b1 || o_icb_cmd_addr !== d.addr) begin n_errors++; $display("FAIL stall_reload: got v=%b a=%h exp 1/%h", o_icb_cmd_valid, o_icb_cmd_addr, d.addr); end
        flush();
    endtask

    task automatic test_rsp_queue();
        o_icb_cmd_ready = 1'b1; i_icb_rsp_ready = 1'b0;
        cmd_at(32'h100); tick();
        cmd_at(32'h104); tick();
        i_icb_cmd_valid = 1'b0; tick();
        for (int k = 0; k < 2; k++) begin
            biu_rsp(32'h1111_0000 + 32'(k), 1'b0);
            #1;
            n_checks++; if (o_icb_rsp_ready !== 1'b1) begin n_errors++; $display("FAIL q_ordy%0d: got %b exp 1", k, o_icb_rsp_ready); end
            tick();
        end
        o_icb_rsp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (i_icb_rsp_valid !== 1'b1 || i_icb_rsp_addr !== 32'h100) begin n_errors++; $display("FAIL q_hold%0d: got v=%b a=%h exp 1/100", k, i_icb_rsp_valid, i_icb_rsp_addr); end
            tick();
        end
        i_icb_rsp_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++; if (i_icb_rsp_valid !== 1'b1 || i_icb_rsp_addr !== 32'h100 + 32'(4 * k) || i_icb_rsp_rdata !== 32'h1111_0000 + 32'(k)) begin
                n_errors++; $display("FAIL q_order%0d: got a=%h d=%h exp %h/%h", k, i_icb_rsp_addr, i_icb_rsp_rdata, 32'h100 + 32'(4 * k), 32'h1111_0000 + 32'(k));
            end
            tick();
        end
        i_icb_rsp_ready = 1'b0;
        #1;
        n_checks++; if (osd_idle !== 1'b1) begin n_errors++; $display("FAIL q_idle: got %b exp 1", osd_idle); end
    endtask

    task automatic test_random();
        bit exp_rdy;
        for (int cyc = 0; cyc < 400; cyc++) begin
            drive_cmd(rand_cmd());
            i_icb_cmd_valid = 1'($urandom_range(0, 1));
            o_icb_cmd_ready = ($urandom_range(0, 9) < 6);
            i_icb_rsp_ready = 1'($urandom_range(0, 1));
            if (m_biu.size() != 0 && $urandom_range(0, 1) == 1) biu_rsp($urandom(), ($urandom_range(0, 3) == 0));
            else o_icb_rsp_valid = 1'b0;
            #1;
            exp_rdy = (m_osd < OSD_MAX) && (m_slice.size() == 0 || o_icb_cmd_ready);
            n_checks++; if (i_icb_cmd_ready !== exp_rdy) begin n_errors++; $display("FAIL rnd_rdy@%0d: got %b exp %b", cyc, i_icb_cmd_ready, exp_rdy); end
            n_checks++; if (osd_cnt !== 2'(m_osd) || osd_idle !== (m_osd == 0 && m_slice.size() == 0)) begin n_errors++; $display("FAIL rnd_cnt@%0d: got cnt=%0d idle=%b exp cnt=%0d", cyc, osd_cnt, osd_idle, m_osd); end
            n_checks++; if (o_icb_cmd_valid !== (m_slice.size() != 0)) begin n_errors++; $display("FAIL rnd_ovld@%0d: got %b exp %b", cyc, o_icb_cmd_valid, m_slice.size() != 0); end
            if (m_slice.size() != 0) begin
                n_checks++; if ({o_icb_cmd_addr, o_icb_cmd_wdata, o_icb_cmd_wmask, o_icb_cmd_size} !== {m_slice[0].addr, m_slice[0].wdata, m_slice[0].wmask, m_slice[0].size}) begin
                    n_errors++; $display("FAIL rnd_ocmd@%0d: got a=%h d=%h exp a=%h d=%h", cyc, o_icb_cmd_addr, o_icb_cmd_wdata, m_slice[0].addr, m_slice[0].wdata);
                end
            end
            n_checks++; if (i_icb_rsp_valid !== (m_rsp.size() != 0)) begin n_errors++; $display("FAIL rnd_ivld@%0d: got %b exp %b", cyc, i_icb_rsp_valid, m_rsp.size() != 0); end
            if (m_rsp.size() != 0) begin
                n_checks++; if ({i_icb_rsp_err, i_icb_rsp_excl_ok, i_icb_rsp_rdata, i_icb_rsp_addr} !== {m_rsp[0].err, m_rsp[0].excl_ok, m_rsp[0].rdata, m_addr[0]}) begin
                    n_errors++; $display("FAIL rnd_irsp@%0d: got e=%b d=%h a=%h exp e=%b d=%h a=%h", cyc, i_icb_rsp_err, i_icb_rsp_rdata, i_icb_rsp_addr, m_rsp[0].err, m_rsp[0].rdata, m_addr[0]);
                end
            end
            if (o_icb_rsp_valid) begin
                n_checks++; if (o_icb_rsp_ready !== 1'b1) begin n_errors++; $display("FAIL rnd_ordy@%0d: got %b exp 1", cyc, o_icb_rsp_ready); end
            end
            tick();
        end
        flush();
        #1;
        n_checks++; if (osd_cnt !== 2'd0 || osd_idle !== 1'b1) begin n_errors++; $display("FAIL rnd_drain: got cnt=%0d idle=%b exp 0/1", osd_cnt, osd_idle); end
    endtask

`ifdef E203_LSU_OSD_ERR_CAPTURE_EN
    task automatic test_err_capture();
        o_icb_cmd_ready = 1'b1; i_icb_rsp_ready = 1'b0; err_clr = 1'b0;
        cmd_at(32'h2000_0008); tick();
        cmd_at(32'h2000_000C); tick();
        i_icb_cmd_valid = 1'b0; tick();
        biu_rsp(32'h0, 1'b1); tick();
        biu_rsp(32'h0, 1'b1); tick();
        o_icb_rsp_valid = 1'b0; i_icb_rsp_ready = 1'b1;
        tick();
        #1;
        n_checks++; if (err_vld !== 1'b1 || err_addr !== 32'h2000_0008) begin n_errors++; $display("FAIL err_first: got v=%b a=%h exp 1/20000008", err_vld, err_addr); end
        tick();
        #1;
        n_checks++; if (err_vld !== m_err_vld || err_addr !== m_err_addr) begin n_errors++; $display("FAIL err_sticky: got v=%b a=%h exp %b/%h", err_vld, err_addr, m_err_vld, m_err_addr); end
        i_icb_rsp_ready = 1'b0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        #1;
        n_checks++; if (err_vld !== 1'b0 || err_addr !== 32'h0) begin n_errors++; $display("FAIL err_clr: got v=%b a=%h exp 0/0", err_vld, err_addr); end
    endtask
`endif

    task automatic test_reset_mid();
        o_icb_cmd_ready = 1'b1; i_icb_rsp_ready = 1'b0;
        cmd_at(32'h500); tick();
        cmd_at(32'h504); tick();
        i_icb_cmd_valid = 1'b0;
        #1;
        n_checks++; if (osd_cnt !== 2'd2) begin n_errors++; $display("FAIL mid_pre: got %0d exp 2", osd_cnt); end
        rst = 1'b1;
        tick();
        n_checks++; if (osd_cnt !== 2'd0 || osd_idle !== 1'b1 || o_icb_cmd_valid !== 1'b0 || i_icb_rsp_valid !== 1'b0) begin
            n_errors++; $display("FAIL mid_rst: got cnt=%0d idle=%b ov=%b iv=%b exp 0/1/0/0", osd_cnt, osd_idle, o_icb_cmd_valid, i_icb_rsp_valid);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        i_icb_cmd_valid = 1'b0; i_icb_cmd_addr = 32'h0; i_icb_cmd_read = 1'b0; i_icb_cmd_wdata = 32'h0;
        i_icb_cmd_wmask = 4'h0; i_icb_cmd_lock = 1'b0; i_icb_cmd_excl = 1'b0; i_icb_cmd_size = 2'b00;
        i_icb_rsp_ready = 1'b0; o_icb_cmd_ready = 1'b0;
        o_icb_rsp_valid = 1'b0; o_icb_rsp_err = 1'b0; o_icb_rsp_excl_ok = 1'b0; o_icb_rsp_rdata = 32'h0;
`ifdef E203_LSU_OSD_ERR_CAPTURE_EN
        err_clr = 1'b0;
`endif
        m_osd = 0; m_err_vld = 1'b0; m_err_addr = 32'h0;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_biu_stall();
        test_rsp_queue();
        test_random();
`ifdef E203_LSU_OSD_ERR_CAPTURE_EN
        test_err_capture();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
